hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised hazard controller for the 5-stage pipeline. Generates per-operand forwarding selects for the Execute stage, load-use stalls, and multi-cycle flushes after a taken branch. It also holds stall state across a variable-latency Execute operation (mul/div). It sits beside the datapath and drives the F/D/E pipeline-register enables and clears.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, source operands checked per instruction (1..3)
- FLUSH_CYCLES, 1, cycles flushD/flushE stay high per taken branch (>=1)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- Dreg_addr  in  NUM_SRC*REG_ADDR_W  Decode source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- Ereg_addr  in  NUM_SRC*REG_ADDR_W  Execute source addresses, same packing
- Ewrite_reg_addr  in  REG_ADDR_W  Execute destination
- Emem_read  in  1  Execute instruction is a load
- Mwrite_reg_addr  in  REG_ADDR_W  Memory-stage destination
- Mwrite_reg_sig  in  1  Memory stage writes a register
- Wwrite_reg_addr  in  REG_ADDR_W  Writeback destination
- Wwrite_reg_sig  in  1  Writeback writes a register
- branch_sig  in  1  taken branch/jump resolved in Execute
- mc_start  in  1  multi-cycle op enters Execute (pulse)
- mc_done  in  1  multi-cycle result valid this cycle (pulse)
- forwardE  out  2*NUM_SRC  forward select per operand, field i at [2*i +: 2]
- stallF, stallD, stallE  out  1  hold respective pipeline register
- flushD, flushE  out  1  clear respective pipeline register

## Operation
- Forwarding, per operand i: address 0 gives NORMAL. Else a match with Mwrite_reg_addr and Mwrite_reg_sig gives WRITEMEM. Else a match with Wwrite_reg_addr and Wwrite_reg_sig gives WRITEBACK. Otherwise NORMAL. M has priority over W.
- Load-use: Emem_read, nonzero Ewrite_reg_addr, and a match with any Dreg_addr field give lu = 1. lu drives stallF = stallD = 1 and flushE = 1 for that cycle.
- Branch flush: a down-counter bcnt, width $clog2(FLUSH_CYCLES+1).
  - branch_sig loads bcnt = FLUSH_CYCLES-1.
  - Otherwise bcnt decrements while nonzero.
  - flush_active = branch_sig | (bcnt != 0). It drives flushD = flushE = 1.
  - A new branch_sig while bcnt != 0 reloads the counter. Flushes do not accumulate.
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE with mc_start and !mc_done: go to BUSY. mc_busy = 1 this cycle.
  - IDLE with mc_start and mc_done: stay IDLE. mc_busy = 0.
  - BUSY with !mc_done: stay BUSY. mc_busy = 1.
  - BUSY with mc_done: go to IDLE. mc_busy = 0 this cycle.
  - mc_start seen while in BUSY is ignored.
- While mc_busy, stallF = stallD = stallE = 1.
- Priority, highest first:
  1. mc_busy. Stalls only; branch_sig and lu are masked, bcnt holds.
  2. flush_active. Flushes only; lu is masked, because D is being discarded.
  3. lu.
- flushE is the OR of the flush_active and lu terms that survive the masking above.

## Timing
- All outputs are combinational from inputs and state. Zero-cycle latency for forwardE, lu and the first flush cycle.
- During reset low, all outputs are forced to 0 and forwardE fields to NORMAL.
- The state registers (FSM = IDLE, bcnt = 0) are cleared on the first rising edge with reset low.
- Reset mid-BUSY or mid-flush returns the block to IDLE with bcnt = 0. No residual stall or flush after reset rises.
- Branch in cycle t with FLUSH_CYCLES = N: flushD/flushE high in cycles t..t+N-1, low at t+N unless another branch arrives.
- Multi-cycle op started at t, done at t+k (k >= 1): stalls high in cycles t..t+k-1, low at t+k.

## Configuration
- HAZARD_LOAD_USE_EN defined: load-use detection as above.
- HAZARD_LOAD_USE_EN undefined: lu is tied to 0 and Emem_read and Dreg_addr are unused. The compiler must schedule a bubble after every load.

## Structure
- The encodings NORMAL = 2'b00, WRITEMEM = 2'b01 and WRITEBACK = 2'b10 live in the shared defines header used by the datapath forwarding muxes.
- The FSM state encodings IDLE = 1'b0 and BUSY = 1'b1 are also defined in the shared defines header.
- One sub-module, fwd_select: a single operand's forwarding compare, instantiated NUM_SRC times in a generate loop.

## Test plan
- Forwarding priority:
  - Ereg_addr op0 = 5, M and W both write reg 5 -> forwardE[1:0] = WRITEMEM.
  - Op0 = 0 with M writing reg 0 -> NORMAL.
  - W-only match on reg 7 -> WRITEBACK.
- Load-use: Emem_read = 1, Ewrite_reg_addr = 3, Dreg_addr op1 = 3 -> stallF = stallD = flushE = 1 for exactly one cycle. With the macro undefined -> all 0.
- Branch with FLUSH_CYCLES = 3:
  - branch_sig at t -> flushD/flushE high t, t+1, t+2; low at t+3.
  - A second branch at t+1 extends the flush through t+3.
- Multi-cycle:
  - mc_start at t, mc_done at t+4 -> stallF/D/E high t..t+3, low at t+4.
  - branch_sig asserted at t+2 produces no flush.
- Reset mid-op:
  - reset low at t+2 of a BUSY sequence -> all outputs 0 during reset.
  - After reset rises with mc_done = 0 -> no stall, FSM in IDLE.

Source files
------------

// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the hazard controller and the datapath forwarding muxes.
package hazard_unit_mc_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NORMAL    = 2'b00;
  localparam fwd_sel_t FWD_WRITEMEM  = 2'b01;
  localparam fwd_sel_t FWD_WRITEBACK = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard controller bundle: pipeline addresses/strobes in, selects/enables out.
interface hazard_unit_mc_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2
);
  logic [NUM_SRC*REG_ADDR_W-1:0] Dreg_addr;
  logic [NUM_SRC*REG_ADDR_W-1:0] Ereg_addr;
  logic [REG_ADDR_W-1:0]         Ewrite_reg_addr;
  logic                          Emem_read;
  logic [REG_ADDR_W-1:0]         Mwrite_reg_addr;
  logic                          Mwrite_reg_sig;
  logic [REG_ADDR_W-1:0]         Wwrite_reg_addr;
  logic                          Wwrite_reg_sig;
  logic                          branch_sig;
  logic                          mc_start;
  logic                          mc_done;
  logic [2*NUM_SRC-1:0]          forwardE;
  logic                          stallF;
  logic                          stallD;
  logic                          stallE;
  logic                          flushD;
  logic                          flushE;

  modport master (
    output Dreg_addr, Ereg_addr, Ewrite_reg_addr, Emem_read,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, mc_start, mc_done,
    input  forwardE, stallF, stallD, stallE, flushD, flushE
  );

  modport slave (
    input  Dreg_addr, Ereg_addr, Ewrite_reg_addr, Emem_read,
           Mwrite_reg_addr, Mwrite_reg_sig, Wwrite_reg_addr, Wwrite_reg_sig,
           branch_sig, mc_start, mc_done,
    output forwardE, stallF, stallD, stallE, flushD, flushE
  );
endinterface

// File: rtl/hazard_unit_mc_fwd_select.sv
// Forwarding select for one Execute source operand; Memory stage wins over Writeback.
module hazard_unit_mc_fwd_select
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [REG_ADDR_W-1:0] m_addr,
  input  logic                  m_sig,
  input  logic [REG_ADDR_W-1:0] w_addr,
  input  logic                  w_sig,
  output fwd_sel_t              sel
);

  // Register 0 is hardwired, so it never takes a forwarded value.
  always_comb begin
    sel = FWD_NORMAL;
    if (addr != '0) begin
      if (m_sig && (addr == m_addr))
        sel = FWD_WRITEMEM;
      else if (w_sig && (addr == w_addr))
        sel = FWD_WRITEBACK;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller: forwarding, load-use stall, branch flush, multi-cycle hold.
// Load-use detection is built only when HAZARD_LOAD_USE_EN is defined.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_mc_if.slave hz
);

  localparam int BCNT_W = $clog2(FLUSH_CYCLES + 1);

  logic [2*NUM_SRC-1:0] fwd_raw;
  logic [0:0]           state, state_nxt;
  logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
  logic                 lu;
  logic                 mc_busy;
  logic                 flush_active;
  logic                 lu_eff;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_unit_mc_fwd_select #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_select (
      .addr  (hz.Ereg_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .m_addr(hz.Mwrite_reg_addr),
      .m_sig (hz.Mwrite_reg_sig),
      .w_addr(hz.Wwrite_reg_addr),
      .w_sig (hz.Wwrite_reg_sig),
      .sel   (fwd_raw[2*i +: 2])
    );
  end

`ifdef HAZARD_LOAD_USE_EN
  always_comb begin
    lu = 1'b0;
    if (hz.Emem_read && (hz.Ewrite_reg_addr != '0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hz.Dreg_addr[i*REG_ADDR_W +: REG_ADDR_W] == hz.Ewrite_reg_addr)
          lu = 1'b1;
      end
    end
  end
`else
  // Without the detector the compiler guarantees a bubble after every load.
  logic unused_lu_inputs;
  assign unused_lu_inputs = ^{hz.Emem_read, hz.Dreg_addr, hz.Ewrite_reg_addr};
  assign lu = 1'b0;
`endif

  // mc_busy covers the start cycle and drops in the cycle mc_done arrives.
  always_comb begin
    state_nxt = state;
    mc_busy   = 1'b0;
    if (state == ST_IDLE) begin
      mc_busy = hz.mc_start & ~hz.mc_done;
      if (hz.mc_start && !hz.mc_done)
        state_nxt = ST_BUSY;
    end else begin
      mc_busy = ~hz.mc_done;
      if (hz.mc_done)
        state_nxt = ST_IDLE;
    end
  end

  // A stalled Execute freezes the flush sequence and ignores new branches.
  always_comb begin
    bcnt_nxt = bcnt;
    if (!mc_busy) begin
      if (hz.branch_sig)
        bcnt_nxt = BCNT_W'(FLUSH_CYCLES - 1);
      else if (bcnt != '0)
        bcnt_nxt = bcnt - BCNT_W'(1);
    end
  end

  assign flush_active = ~mc_busy & (hz.branch_sig | (bcnt != '0));
  assign lu_eff       = ~mc_busy & ~flush_active & lu;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    hz.forwardE = {NUM_SRC{FWD_NORMAL}};
    hz.stallF   = 1'b0;
    hz.stallD   = 1'b0;
    hz.stallE   = 1'b0;
    hz.flushD   = 1'b0;
    hz.flushE   = 1'b0;
    if (reset) begin
      hz.forwardE = fwd_raw;
      hz.stallF   = mc_busy | lu_eff;
      hz.stallD   = mc_busy | lu_eff;
      hz.stallE   = mc_busy;
      hz.flushD   = flush_active;
      hz.flushE   = flush_active | lu_eff;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc with FLUSH_CYCLES = 3 and two source operands.
module tb_hazard_unit_mc;
  import hazard_unit_mc_pkg::*;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int FC = 3;
`ifdef HAZARD_LOAD_USE_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_ADDR_W(RW), .NUM_SRC(NS)) hz ();

  hazard_unit_mc #(
    .REG_ADDR_W  (RW),
    .NUM_SRC     (NS),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  // Expected response packing: {forwardE[3:0], stallF, stallD, stallE, flushD, flushE}
  typedef struct {
    string      name;
    logic [8:0] resp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [2:0] lu_st;
  logic [1:0] lu_fl;

  task automatic clear_inputs();
    reset              = 1'b1;
    hz.Dreg_addr       = '0;
    hz.Ereg_addr       = '0;
    hz.Ewrite_reg_addr = '0;
    hz.Emem_read       = 1'b0;
    hz.Mwrite_reg_addr = '0;
    hz.Mwrite_reg_sig  = 1'b0;
    hz.Wwrite_reg_addr = '0;
    hz.Wwrite_reg_sig  = 1'b0;
    hz.branch_sig      = 1'b0;
    hz.mc_start        = 1'b0;
    hz.mc_done         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_e(input int op, input logic [RW-1:0] a);
    hz.Ereg_addr[op*RW +: RW] = a;
  endtask

  task automatic set_d(input int op, input logic [RW-1:0] a);
    hz.Dreg_addr[op*RW +: RW] = a;
  endtask

  task automatic set_load_use();
    hz.Emem_read       = 1'b1;
    hz.Ewrite_reg_addr = 5'd3;
    set_d(1, 5'd3);
  endtask

  task automatic expect_resp(input string name, input logic [3:0] fwd,
                             input logic [2:0] st, input logic [1:0] fl);
    exp_t e;
    e.name = name;
    e.resp = {fwd, st, fl};
    sb.push_back(e);
  endtask

  initial begin
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {hz.forwardE, hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE};
        checks++;
        if (got !== e.resp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, got, e.resp);
        end
      end
    end
  end

  initial begin
    lu_st = LU_EN ? 3'b110 : 3'b000;
    lu_fl = LU_EN ? 2'b01 : 2'b00;
    clear_inputs();
    reset = 1'b0;

    // Reset forces outputs low even with every hazard source active
    tick(); reset = 1'b0; hz.mc_start = 1'b1; hz.branch_sig = 1'b1;
    set_e(0, 5'd5); hz.Mwrite_reg_addr = 5'd5; hz.Mwrite_reg_sig = 1'b1;
    expect_resp("rst_outputs", 4'b0000, 3'b000, 2'b00);
    tick(); reset = 1'b0; set_load_use();
    expect_resp("rst_lu", 4'b0000, 3'b000, 2'b00);

    // Forwarding
    tick(); set_e(0, 5'd5); hz.Mwrite_reg_addr = 5'd5; hz.Mwrite_reg_sig = 1'b1;
    hz.Wwrite_reg_addr = 5'd5; hz.Wwrite_reg_sig = 1'b1;
    expect_resp("fwd_m_over_w", 4'b0001, 3'b000, 2'b00);
    tick(); hz.Mwrite_reg_sig = 1'b1; hz.Wwrite_reg_sig = 1'b1;
    expect_resp("fwd_reg0", 4'b0000, 3'b000, 2'b00);
    tick(); set_e(0, 5'd7); set_e(1, 5'd3);
    hz.Mwrite_reg_addr = 5'd3; hz.Mwrite_reg_sig = 1'b1;
    hz.Wwrite_reg_addr = 5'd7; hz.Wwrite_reg_sig = 1'b1;
    expect_resp("fwd_w_only", 4'b0110, 3'b000, 2'b00);
    tick(); set_e(1, 5'd9); hz.Mwrite_reg_addr = 5'd9;
    hz.Wwrite_reg_addr = 5'd9; hz.Wwrite_reg_sig = 1'b1;
    expect_resp("fwd_m_nowrite", 4'b1000, 3'b000, 2'b00);

    // Load-use
    tick(); set_load_use();
    expect_resp("lu_hit", 4'b0000, lu_st, lu_fl);
    tick();
    expect_resp("lu_one_cycle", 4'b0000, 3'b000, 2'b00);
    tick(); hz.Emem_read = 1'b1;
    expect_resp("lu_dest0", 4'b0000, 3'b000, 2'b00);
    tick(); hz.Ewrite_reg_addr = 5'd3; set_d(0, 5'd3);
    expect_resp("lu_not_load", 4'b0000, 3'b000, 2'b00);

    // Single branch, load-use masked during flush
    tick(); hz.branch_sig = 1'b1;
    expect_resp("br_t0", 4'b0000, 3'b000, 2'b11);
    tick(); set_load_use();
    expect_resp("br_t1_lu_masked", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("br_t2", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("br_t3_low", 4'b0000, 3'b000, 2'b00);

    // Back-to-back branches reload rather than accumulate
    tick(); hz.branch_sig = 1'b1;
    expect_resp("br2_t0", 4'b0000, 3'b000, 2'b11);
    tick(); hz.branch_sig = 1'b1;
    expect_resp("br2_t1", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("br2_t2", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("br2_t3", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("br2_t4_low", 4'b0000, 3'b000, 2'b00);

    // Multi-cycle op k=4 with a masked branch at t+2
    tick(); hz.mc_start = 1'b1;
    expect_resp("mc_t0", 4'b0000, 3'b111, 2'b00);
    tick();
    expect_resp("mc_t1", 4'b0000, 3'b111, 2'b00);
    tick(); hz.branch_sig = 1'b1;
    expect_resp("mc_t2_branch", 4'b0000, 3'b111, 2'b00);
    tick(); set_load_use();
    expect_resp("mc_t3_lu", 4'b0000, 3'b111, 2'b00);
    tick(); hz.mc_done = 1'b1;
    expect_resp("mc_t4_done", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("mc_t5_noflush", 4'b0000, 3'b000, 2'b00);

    // Start and done together stays idle
    tick(); hz.mc_start = 1'b1; hz.mc_done = 1'b1;
    expect_resp("mc_same_cycle", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("mc_same_after", 4'b0000, 3'b000, 2'b00);

    // Flush counter holds across a stall and resumes afterwards
    tick(); hz.branch_sig = 1'b1;
    expect_resp("hold_br", 4'b0000, 3'b000, 2'b11);
    tick(); hz.mc_start = 1'b1;
    expect_resp("hold_busy", 4'b0000, 3'b111, 2'b00);
    tick(); hz.mc_done = 1'b1;
    expect_resp("hold_resume1", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("hold_resume2", 4'b0000, 3'b000, 2'b11);
    tick();
    expect_resp("hold_end", 4'b0000, 3'b000, 2'b00);

    // mc_start while busy is ignored
    tick(); hz.mc_start = 1'b1;
    expect_resp("ign_t0", 4'b0000, 3'b111, 2'b00);
    tick(); hz.mc_start = 1'b1;
    expect_resp("ign_t1", 4'b0000, 3'b111, 2'b00);
    tick(); hz.mc_done = 1'b1;
    expect_resp("ign_done", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("ign_idle", 4'b0000, 3'b000, 2'b00);

    // Reset in the middle of a BUSY sequence
    tick(); hz.mc_start = 1'b1;
    expect_resp("rbusy_t0", 4'b0000, 3'b111, 2'b00);
    tick();
    expect_resp("rbusy_t1", 4'b0000, 3'b111, 2'b00);
    tick(); reset = 1'b0; set_e(0, 5'd5);
    hz.Mwrite_reg_addr = 5'd5; hz.Mwrite_reg_sig = 1'b1;
    expect_resp("rbusy_reset", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("rbusy_after", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("rbusy_after2", 4'b0000, 3'b000, 2'b00);

    // Reset in the middle of a flush
    tick(); hz.branch_sig = 1'b1;
    expect_resp("rflush_br", 4'b0000, 3'b000, 2'b11);
    tick(); reset = 1'b0;
    expect_resp("rflush_reset", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("rflush_after", 4'b0000, 3'b000, 2'b00);
    tick();
    expect_resp("rflush_after2", 4'b0000, 3'b000, 2'b00);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
